// File: rtl/equilibrio_juiz.sv
// equilibrio_juiz - round judge for the balance game.
//
// On each new-round request it draws a pseudo-random target position and a
// tolerance window that depends on the level. While the round is live it
// watches the sampled platform position. When the round ends it sends a
// one-cycle ponto_evento pulse back to the game control unit, with acerto
// set for a hit (position held in the window) or clear for a miss (timeout).
//
// Ports:
//   clock              single clock, all state on the rising edge
//   reset              synchronous, active-high
//   gerar_nova_jogada  one-cycle pulse: start a new round (valid in any state)
//   conta_nivel        high while the control unit is in its play state
//   reset_nivel        level-high clear of pontos
//   nivel              difficulty 0..3, sampled with gerar_nova_jogada
//   pos_valid          one-cycle strobe qualifying pos
//   pos                platform position, unsigned
//   ponto_evento       one-cycle round-end pulse (decoded from DONE)
//   acerto             result of the last round, 1 = hit
//   alvo               current target position
//   pontos             saturating hit count
//   db_estado          debug state: IDLE=00 ARMED=01 TRACK=10 DONE=11
module equilibrio_juiz #(
    parameter int         HOLD_SAMPLES   = 16,
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter int         SCORE_WIDTH    = 8,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   gerar_nova_jogada,
    input  logic                   conta_nivel,
    input  logic                   reset_nivel,
    input  logic [1:0]             nivel,
    input  logic                   pos_valid,
    input  logic [7:0]             pos,
    output logic                   ponto_evento,
    output logic                   acerto,
    output logic [7:0]             alvo,
    output logic [SCORE_WIDTH-1:0] pontos,
    output logic [1:0]             db_estado
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam int HOLD_W  = $clog2(HOLD_SAMPLES + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        TRACK = 2'b10,
        DONE  = 2'b11
    } estado_t;

    estado_t            estado;
    logic [7:0]         lfsr;
    logic [4:0]         tol;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [TIMER_W-1:0] timer;
    logic               in_janela;
    logic               hit;

    // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // The window halves with each level: 16, 8, 4, 2.
    function automatic logic [4:0] tol_for(input logic [1:0] n);
        return 5'd16 >> n;
    endfunction

    // |p - a| <= t. The difference is taken as 9-bit signed so that the full
    // unsigned 8-bit range cannot wrap.
    function automatic logic window_hit(input logic [7:0] p,
                                        input logic [7:0] a,
                                        input logic [4:0] t);
        logic signed [8:0] d;
        logic [8:0]        mag;
        d   = $signed({1'b0, p}) - $signed({1'b0, a});
        mag = d[8] ? $unsigned(-d) : $unsigned(d);
        return mag <= {4'b0000, t};
    endfunction

    function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] v);
        return (&v) ? v : v + SCORE_WIDTH'(1);
    endfunction

    always_comb begin
        in_janela = window_hit(pos, alvo, tol);
        hit       = (estado == TRACK) && pos_valid && in_janela && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= IDLE;
            lfsr     <= LFSR_SEED;
            alvo     <= 8'h80;
            tol      <= 5'd16;
            hold_cnt <= '0;
            timer    <= '0;
            acerto   <= 1'b0;
            pontos   <= '0;
        end else begin
            lfsr <= lfsr_step(lfsr);

            // A round load overrides whatever the current state is doing,
            // including aborting a live round without an event.
            if (gerar_nova_jogada) begin
                alvo     <= {1'b0, lfsr[6:0]} + 8'd64;
                tol      <= tol_for(nivel);
                hold_cnt <= '0;
                timer    <= '0;
                estado   <= ARMED;
            end else begin
                case (estado)
                    IDLE: ;
                    ARMED: begin
                        if (conta_nivel) estado <= TRACK;
                    end
                    TRACK: begin
                        timer <= timer + 1'b1;
                        if (pos_valid) hold_cnt <= in_janela ? hold_cnt + 1'b1 : '0;
                        // Priority: hit, then timeout, then leaving play state.
                        if (hit) begin
                            acerto <= 1'b1;
                            pontos <= sat_inc(pontos);
                            estado <= DONE;
                        end else if (timer == TIMER_LAST) begin
                            acerto <= 1'b0;
                            estado <= DONE;
                        end else if (!conta_nivel) begin
                            estado <= IDLE;
                        end
                    end
                    DONE: estado <= IDLE;
                    default: estado <= IDLE;
                endcase
            end

            // Placed last so a clear beats a simultaneous hit increment.
            if (reset_nivel) pontos <= '0;
        end
    end

    assign ponto_evento = (estado == DONE);
    assign db_estado    = estado;

endmodule

// File: tb/tb_equilibrio_juiz.sv
// Self-checking bench for equilibrio_juiz with a round-level reference model.
module tb_equilibrio_juiz;

    localparam int HOLD = 4;
    localparam int TO   = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       gerar_nova_jogada = 1'b0;
    logic       conta_nivel = 1'b0;
    logic       reset_nivel = 1'b0;
    logic [1:0] nivel = 2'd0;
    logic       pos_valid = 1'b0;
    logic [7:0] pos = 8'd0;
    logic       ponto_evento;
    logic       acerto;
    logic [7:0] alvo;
    logic [7:0] pontos;
    logic [1:0] db_estado;

    int n_chk  = 0;
    int n_fail = 0;
    int n_adv  = 0;   // LFSR advances since the last reset edge

    // Round model state.
    logic [7:0] m_alvo;
    int         m_tol;
    int         m_run;
    int         m_k;
    int         m_pontos;
    logic       m_acerto;

    equilibrio_juiz #(
        .HOLD_SAMPLES  (HOLD),
        .TIMEOUT_CYCLES(TO),
        .SCORE_WIDTH   (8),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .gerar_nova_jogada(gerar_nova_jogada),
        .conta_nivel      (conta_nivel),
        .reset_nivel      (reset_nivel),
        .nivel            (nivel),
        .pos_valid        (pos_valid),
        .pos              (pos),
        .ponto_evento     (ponto_evento),
        .acerto           (acerto),
        .alvo             (alvo),
        .pontos           (pontos),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) n_adv <= 0;
        else       n_adv <= n_adv + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sequence value after n steps from the seed; feedback is the parity of
    // the tapped bits 8,6,5,4 (mask 0xB8).
    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
        return v;
    endfunction

    task automatic check_reset_state();
        check_eq("rst_estado", db_estado, 2'b00);
        check_eq("rst_alvo", alvo, 8'h80);
        check_eq("rst_pontos", pontos, 0);
        check_eq("rst_acerto", acerto, 0);
        check_eq("rst_evento", ponto_evento, 0);
        m_pontos = 0;
        m_acerto = 1'b0;
        m_alvo   = 8'h80;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        check_reset_state();
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] nv);
        logic [7:0] lf;
        lf = lfsr_after(n_adv);
        gerar_nova_jogada = 1'b1;
        nivel = nv;
        step();
        gerar_nova_jogada = 1'b0;
        m_alvo = {1'b0, lf[6:0]} + 8'd64;
        m_tol  = 16 >> nv;
        m_run  = 0;
        m_k    = 0;
        check_eq("load_alvo", alvo, m_alvo);
        check_eq("load_estado", db_estado, 2'b01);
        check_eq("load_evento", ponto_evento, 0);
        check_eq("load_pontos", pontos, m_pontos);
    endtask

    task automatic enter_track();
        conta_nivel = 1'b1;
        step();
        check_eq("track_estado", db_estado, 2'b10);
    endtask

    // One TRACK cycle: predict from the round rules, drive, then compare.
    task automatic drive_track(input logic v, input logic [7:0] p, input logic rn,
                               input logic ct, output logic ended);
        int  d;
        logic inwin, exp_hit, exp_miss, exp_abort;
        d = int'(p) - int'(m_alvo);
        if (d < 0) d = -d;
        inwin     = v && (d <= m_tol);
        exp_hit   = inwin && (m_run + 1 == HOLD);
        exp_miss  = !exp_hit && (m_k == TO - 1);
        exp_abort = !exp_hit && !exp_miss && !ct;

        pos_valid = v; pos = p; reset_nivel = rn; conta_nivel = ct;
        step();
        pos_valid = 1'b0; reset_nivel = 1'b0;

        if (rn) m_pontos = 0;
        else if (exp_hit && m_pontos < 255) m_pontos++;
        if (exp_hit || exp_miss) m_acerto = exp_hit;

        check_eq("evento", ponto_evento, exp_hit || exp_miss);
        check_eq("pontos", pontos, m_pontos);
        check_eq("acerto", acerto, m_acerto);
        ended = 1'b1;
        if (exp_hit || exp_miss) begin
            check_eq("done_estado", db_estado, 2'b11);
            step();
            check_eq("pulse_width", ponto_evento, 0);
            check_eq("post_done_estado", db_estado, 2'b00);
        end else if (exp_abort) begin
            check_eq("abort_estado", db_estado, 2'b00);
        end else begin
            check_eq("live_estado", db_estado, 2'b10);
            if (v) m_run = inwin ? m_run + 1 : 0;
            m_k++;
            ended = 1'b0;
        end
    endtask

    task automatic quick_hit(input logic rn_last);
        logic e;
        do_load(2'($urandom_range(0, 3)));
        enter_track();
        for (int i = 0; i < HOLD; i++) drive_track(1'b1, m_alvo, (i == HOLD - 1) ? rn_last : 1'b0, 1'b1, e);
        check_eq("quick_hit_ended", e, 1);
    endtask

    task automatic rand_round();
        logic       e, v, ct, rn;
        logic [7:0] p;
        int         off;
        do_load(2'($urandom_range(0, 3)));
        enter_track();
        e = 1'b0;
        while (!e) begin
            v  = ($urandom_range(0, 3) != 0);
            ct = ($urandom_range(0, 149) != 0);
            rn = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) != 0) begin
                off = int'($urandom_range(0, 2 * m_tol + 4)) - (m_tol + 2);
                p   = 8'(int'(m_alvo) + off);
            end else begin
                p = 8'($urandom_range(0, 255));
            end
            drive_track(v, p, rn, ct, e);
        end
    endtask

    initial begin
        logic e;
        // Reset state.
        repeat (3) step();
        check_reset_state();

        // First load straight out of reset: seed 0xA5 gives target 0x65.
        reset = 1'b0;
        do_load(2'd0);
        check_eq("first_alvo", alvo, 8'h65);
        enter_track();
        for (int i = 0; i < HOLD; i++) drive_track(1'b1, 8'h75, 1'b0, 1'b1, e);
        check_eq("hit_pontos", pontos, 1);
        check_eq("hit_acerto", acerto, 1);

        // Reset in the middle of a round.
        do_load(2'd1);
        enter_track();
        drive_track(1'b1, m_alvo, 1'b0, 1'b1, e);
        do_reset();

        // Hold counter restarts on an out-of-window sample.
        do_load(2'd0);
        check_eq("second_alvo", alvo, 8'h65);
        enter_track();
        drive_track(1'b1, 8'h75, 1'b0, 1'b1, e);
        drive_track(1'b1, 8'h76, 1'b0, 1'b1, e);
        for (int i = 0; i < HOLD; i++) drive_track(1'b1, 8'h65, 1'b0, 1'b1, e);
        check_eq("restart_hit", acerto, 1);

        // Timeout miss at the hardest level.
        do_load(2'd3);
        enter_track();
        e = 1'b0;
        for (int i = 0; i < TO + 5 && !e; i++) drive_track(1'b1, 8'h00, 1'b0, 1'b1, e);
        check_eq("miss_acerto", acerto, 0);
        check_eq("miss_pontos", pontos, 1);

        // Leaving the play state aborts silently.
        do_load(2'd2);
        enter_track();
        drive_track(1'b1, 8'h00, 1'b0, 1'b1, e);
        drive_track(1'b1, m_alvo, 1'b0, 1'b0, e);
        step();
        check_eq("abort_idle", db_estado, 2'b00);

        // A new round request mid-TRACK reloads without an event.
        do_load(2'd0);
        enter_track();
        drive_track(1'b1, m_alvo, 1'b0, 1'b1, e);
        do_load(2'd1);
        enter_track();
        for (int i = 0; i < HOLD; i++) drive_track(1'b1, m_alvo, 1'b0, 1'b1, e);

        // Saturation, then a hit coinciding with reset_nivel.
        while (m_pontos != 255) quick_hit(1'b0);
        quick_hit(1'b0);
        check_eq("sat_pontos", pontos, 8'hFF);
        quick_hit(1'b1);
        check_eq("clear_wins", pontos, 0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) rand_round();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/equilibrio_juiz.md
# equilibrio_juiz

Round judge for the balance game: on each new-round request from the game control unit it draws a pseudo-random target position and a level-dependent tolerance window. While the round is live it tracks the sampled platform position and issues the one-cycle `ponto_evento` pulse back to the control unit, flagged hit (held in window) or miss (timeout). It sits directly beside the game control unit: it consumes `gerar_nova_jogada`, `conta_nivel` and `reset_nivel`, and produces `ponto_evento`.

## Interface
- `HOLD_SAMPLES`, 16: consecutive in-window `pos_valid` samples required for a hit (≥1).
- `TIMEOUT_CYCLES`, 50_000_000: TRACK cycles before a miss (≥2).
- `SCORE_WIDTH`, 8: width of `pontos`.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `gerar_nova_jogada`  in  1  one-cycle pulse from the control unit: start a new round.
- `conta_nivel`  in  1  high while the control unit is in its play state.
- `reset_nivel`  in  1  level-high clear of `pontos`.
- `nivel`  in  2  difficulty, sampled on `gerar_nova_jogada`.
- `pos_valid`  in  1  one-cycle strobe qualifying `pos`.
- `pos`  in  8  platform position, unsigned.
- `ponto_evento`  out  1  one-cycle round-end pulse.
- `acerto`  out  1  result of the last round (1 = hit); held until next event.
- `alvo`  out  8  current target.
- `pontos`  out  SCORE_WIDTH  saturating hit count.
- `db_estado`  out  2  IDLE=00, ARMED=01, TRACK=10, DONE=11.

## Operation
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every non-reset cycle, free-running in all states.
- Round load, on `gerar_nova_jogada` in any state:
  - `alvo` ← {1'b0, lfsr[6:0]} + 64, giving range 64..191 with no wrap.
  - `tol` ← 16/8/4/2 for `nivel` 0/1/2/3.
  - Hold counter and timer cleared; go to ARMED.
  - A load in TRACK aborts the round with no event.
- ARMED: go to TRACK on the first cycle with `conta_nivel`=1.
- In-window test: |pos − alvo| ≤ tol, computed on a 9-bit signed difference. Equality counts as in-window.
- TRACK, every cycle:
  - Timer increments.
  - On `pos_valid`: in-window → hold_cnt+1; out-of-window → hold_cnt←0.
  - Hit: a valid in-window sample that brings hold_cnt to HOLD_SAMPLES. Set `acerto`←1, `pontos`←`pontos`+1 (saturating at all-ones), go to DONE.
  - Miss: timer reaches TIMEOUT_CYCLES−1 with no hit. Set `acerto`←0, go to DONE.
  - A hit and a miss in the same cycle resolve as a hit.
  - `conta_nivel`=0 → IDLE, no event, `acerto`/`pontos` unchanged. This check has lowest priority except that a round load overrides everything.
- DONE: `ponto_evento`=1 (decoded from state). Unconditionally go to IDLE next cycle, or to ARMED if `gerar_nova_jogada` arrives.
- IDLE: waits for `gerar_nova_jogada`; `pos_valid` is ignored.
- `reset_nivel`: clears `pontos` each cycle it is high. If it coincides with a hit, the clear wins.
- Reset values:
  - State IDLE.
  - `alvo`=8'h80, `tol`=16.
  - lfsr=`LFSR_SEED`.
  - `pontos`=0, `acerto`=0, `ponto_evento`=0.
  - Counters 0.

## Timing
- `alvo` is updated the cycle after the `gerar_nova_jogada` edge.
- The ARMED→TRACK transition takes 1 cycle after `conta_nivel` is sampled high.
- Hit/miss decided at edge N: `ponto_evento`, `acerto` and `pontos` are visible together in cycle N+1. The pulse is exactly one cycle wide.
- Miss pulse appears TIMEOUT_CYCLES cycles after TRACK entry.
- Back-to-back `pos_valid` on every cycle is supported.

## Test plan
- Reset, then lfsr = 8'hA5 and `gerar_nova_jogada` with `nivel`=0 → `alvo` = 0x25+64 = 0x65, tol 16, `db_estado`=01.
- HOLD_SAMPLES=4, `alvo`=0x65, `nivel`=0, `conta_nivel`=1, four valid samples at 0x75 (boundary) → single `ponto_evento` one cycle after the 4th sample, `acerto`=1, `pontos` 0→1.
- Same setup, samples 0x75, 0x76, then four at 0x65 → hold counter resets on 0x76; hit only after the fourth 0x65 sample.
- TIMEOUT_CYCLES=100, `nivel`=3, `pos`=0x00 every cycle → `ponto_evento` 100 cycles after TRACK entry, `acerto`=0, `pontos` unchanged.
- `pontos`=0xFF plus a hit → stays 0xFF. Hit with `reset_nivel`=1 in the same cycle → `pontos`=0, pulse still issued.
- Abort cases:
  - `conta_nivel` dropped mid-TRACK → IDLE, no pulse.
  - `gerar_nova_jogada` mid-TRACK → new `alvo`, ARMED, no pulse.
  - `reset` mid-TRACK → all reset values on the next cycle.
